// File: rtl/button_conditioner_if.sv
// Signal bundle between the GPIO push-button pins and button_conditioner.
// There is no valid/ready handshake: btn_raw is asynchronous, and every output is a registered USER_CLK level or a one-cycle pulse.
interface button_conditioner_if #(
   parameter int NUM_BTN = 3
);
   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_press;
   logic [NUM_BTN-1:0] btn_release;
   logic [NUM_BTN-1:0] btn_press_str;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_press,
      input  btn_release,
      input  btn_press_str
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_press,
      output btn_release,
      output btn_press_str
   );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel button conditioning: 2-FF synchronizer, counter debouncer, and press/release pulses.
// It also makes a press pulse stretched wide enough for the USER_CLK/32 slowerCLK domain to sample.
module button_conditioner #(
   parameter int NUM_BTN         = 3,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int PULSE_CYCLES    = 32
) (
   input  logic                 USER_CLK,
   input  logic                 reset,
   button_conditioner_if.slave  bus
);
   localparam int DCW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int PCW = $clog2(PULSE_CYCLES) + 1;
   localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PCW-1:0] ST_LOAD = PCW'(PULSE_CYCLES);

   logic [NUM_BTN-1:0] s1, s2, level, level_d;
   logic [NUM_BTN-1:0] press_q, release_q, str_q;
   logic [NUM_BTN-1:0] level_nxt, rise, fall, str_nxt;
   logic [DCW-1:0]     db_cnt [NUM_BTN];
   logic [DCW-1:0]     db_nxt [NUM_BTN];
   logic [PCW-1:0]     st_cnt [NUM_BTN];
   logic [PCW-1:0]     st_nxt [NUM_BTN];

   always_comb begin
      level_nxt = level;
      rise      = '0;
      fall      = '0;
      str_nxt   = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         db_nxt[i] = '0;
         st_nxt[i] = '0;
         // Any sample that agrees with the current level restarts the count.
         if (s2[i] != level[i]) begin
            if (db_cnt[i] == DB_LAST) begin
               level_nxt[i] = s2[i];
            end else begin
               db_nxt[i] = db_cnt[i] + DCW'(1);
            end
         end
         rise[i] = level[i] & ~level_d[i];
         fall[i] = ~level[i] & level_d[i];
         // A press reloads the stretch, so overlapping presses give one continuous pulse.
         if (rise[i]) begin
            st_nxt[i] = ST_LOAD;
         end else if (st_cnt[i] != '0) begin
            st_nxt[i] = st_cnt[i] - PCW'(1);
         end
         str_nxt[i] = (st_nxt[i] != '0);
      end
   end

   always_ff @(posedge USER_CLK or posedge reset) begin
      if (reset) begin
         s1        <= '0;
         s2        <= '0;
         level     <= '0;
         level_d   <= '0;
         press_q   <= '0;
         release_q <= '0;
         str_q     <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt[i] <= '0;
            st_cnt[i] <= '0;
         end
      end else begin
         s1        <= bus.btn_raw;
         s2        <= s1;
         level     <= level_nxt;
         level_d   <= level;
         press_q   <= rise;
         release_q <= fall;
         str_q     <= str_nxt;
         for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt[i] <= db_nxt[i];
            st_cnt[i] <= st_nxt[i];
         end
      end
   end

   assign bus.btn_level     = level;
   assign bus.btn_press     = press_q;
   assign bus.btn_release   = release_q;
   assign bus.btn_press_str = str_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: dut1 (debounce 4, stretch 8) and dut2 (debounce 2, stretch 32).
// Expected pulse events are queued when stimulus is driven and matched as the outputs appear.
module tb_button_conditioner;
   localparam int K_PRESS = 1;
   localparam int K_REL   = 2;
   localparam int K_STRR  = 3;
   localparam int K_STRF  = 4;

   logic USER_CLK = 1'b0;
   logic reset    = 1'b1;
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mon_en   = 1'b0;
   logic [2:0] str1_prev = '0;
   logic [2:0] str2_prev = '0;
   logic       slow_prev = 1'b0;
   int         slow_cnt  = 0;
   logic [31:0] exp_q[$];

   button_conditioner_if #(.NUM_BTN(3)) bus1 ();
   button_conditioner_if #(.NUM_BTN(3)) bus2 ();

   button_conditioner #(.NUM_BTN(3), .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(8)) dut1 (
      .USER_CLK (USER_CLK),
      .reset    (reset),
      .bus      (bus1.slave)
   );

   button_conditioner #(.NUM_BTN(3), .DEBOUNCE_CYCLES(2), .PULSE_CYCLES(32)) dut2 (
      .USER_CLK (USER_CLK),
      .reset    (reset),
      .bus      (bus2.slave)
   );

   // Clock and cycle counter: cyc equals the number of rising edges seen so far.
   always #5 USER_CLK = ~USER_CLK;
   always @(posedge USER_CLK) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exhausted at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ev(input int kind, input int ch, input int c);
      return {kind[3:0], ch[3:0], c[23:0]};
   endfunction

   task automatic push_ev(input int kind, input int ch, input int c);
      exp_q.push_back(ev(kind, ch, c));
   endtask

   // Match an observed event against the oldest pending event of the same kind and channel.
   task automatic observe(input int kind, input int ch, input int c);
      int idx = -1;
      logic [31:0] e = ev(kind, ch, c);
      foreach (exp_q[j])
         if (idx < 0 && exp_q[j][31:24] == e[31:24]) idx = j;
      if (idx >= 0) begin
         check_eq("event", e, exp_q[idx]);
         exp_q.delete(idx);
      end else begin
         check_eq("event_unexpected", e, 32'd0);
      end
   endtask

   always @(negedge USER_CLK) begin
      if (mon_en) begin
         for (int i = 0; i < 3; i++) begin
            if (bus1.btn_press[i])                         observe(K_PRESS, i, cyc);
            if (bus1.btn_release[i])                       observe(K_REL, i, cyc);
            if (bus1.btn_press_str[i] && !str1_prev[i])    observe(K_STRR, i, cyc);
            if (!bus1.btn_press_str[i] && str1_prev[i])    observe(K_STRF, i, cyc);
            if (bus2.btn_press[i])                         observe(K_PRESS, i + 4, cyc);
            if (bus2.btn_release[i])                       observe(K_REL, i + 4, cyc);
            if (bus2.btn_press_str[i] && !str2_prev[i])    observe(K_STRR, i + 4, cyc);
            if (!bus2.btn_press_str[i] && str2_prev[i])    observe(K_STRF, i + 4, cyc);
         end
         str1_prev = bus1.btn_press_str;
         str2_prev = bus2.btn_press_str;
         // slowerCLK consumer: samples nextString once every 32 cycles.
         if (cyc[4:0] == 5'd0) begin
            if (bus2.btn_press_str[2] && !slow_prev) slow_cnt++;
            slow_prev = bus2.btn_press_str[2];
         end
      end
   end

   task automatic goto(input int n);
      while (cyc < n) @(negedge USER_CLK);
   endtask

   task automatic check_zero1(input string tag);
      check_eq({tag, "_level"}, bus1.btn_level, 3'b000);
      check_eq({tag, "_press"}, bus1.btn_press, 3'b000);
      check_eq({tag, "_release"}, bus1.btn_release, 3'b000);
      check_eq({tag, "_str"}, bus1.btn_press_str, 3'b000);
   endtask

   initial begin
      int t0, b, c, a, d, e, t1, r;
      bus1.btn_raw = '0;
      bus2.btn_raw = '0;
      repeat (4) @(negedge USER_CLK);
      check_zero1("reset");
      check_eq("reset_dut2_str", bus2.btn_press_str, 3'b000);
      reset = 1'b0;
      t0 = cyc;
      mon_en = 1'b1;

      // Clean press on channel 0.
      goto(t0 + 9);
      bus1.btn_raw[0] = 1'b1;
      push_ev(K_PRESS, 0, t0 + 16);
      push_ev(K_STRR, 0, t0 + 16);
      push_ev(K_STRF, 0, t0 + 24);
      goto(t0 + 1);
      check_zero1("first_edge");
      goto(t0 + 14);
      check_eq("t1_level_pre", bus1.btn_level, 3'b000);
      goto(t0 + 15);
      check_eq("t1_level_rise", bus1.btn_level, 3'b001);
      goto(t0 + 16);
      check_eq("t1_press", bus1.btn_press, 3'b001);
      goto(t0 + 17);
      check_eq("t1_press_gone", bus1.btn_press, 3'b000);

      // Three-cycle low glitch is ignored, then a real release.
      goto(t0 + 25);
      bus1.btn_raw[0] = 1'b0;
      goto(t0 + 28);
      bus1.btn_raw[0] = 1'b1;
      goto(t0 + 33);
      check_eq("t3_glitch_level", bus1.btn_level, 3'b001);
      goto(t0 + 34);
      bus1.btn_raw[0] = 1'b0;
      push_ev(K_REL, 0, t0 + 41);
      goto(t0 + 39);
      check_eq("t3_level_hold", bus1.btn_level, 3'b001);
      goto(t0 + 40);
      check_eq("t3_level_fall", bus1.btn_level, 3'b000);

      // Bounce on channel 1: 1,0,1,0 with 3-cycle dwell, then a steady hold.
      b = t0 + 50;
      for (int k = 0; k < 4; k++) begin
         goto(b + 3 * k);
         bus1.btn_raw[1] = (k % 2 == 0);
      end
      goto(b + 12);
      bus1.btn_raw[1] = 1'b1;
      push_ev(K_PRESS, 1, b + 19);
      push_ev(K_STRR, 1, b + 19);
      push_ev(K_REL, 1, b + 26);
      push_ev(K_STRF, 1, b + 27);
      goto(b + 17);
      check_eq("t2_level_pre", bus1.btn_level, 3'b000);
      goto(b + 18);
      check_eq("t2_level_rise", bus1.btn_level, 3'b010);
      goto(b + 19);
      bus1.btn_raw[1] = 1'b0;
      goto(b + 26);
      check_eq("t3_release_in_stretch", bus1.btn_release, 3'b010);
      check_eq("t3_str_kept", bus1.btn_press_str, 3'b010);

      // All three channels pressed together.
      c = b + 40;
      goto(c);
      bus1.btn_raw = 3'b111;
      for (int i = 0; i < 3; i++) begin
         push_ev(K_PRESS, i, c + 7);
         push_ev(K_STRR, i, c + 7);
         push_ev(K_STRF, i, c + 15);
         push_ev(K_REL, i, c + 27);
      end
      goto(c + 7);
      check_eq("t6_press_all", bus1.btn_press, 3'b111);
      check_eq("t6_release_none", bus1.btn_release, 3'b000);
      goto(c + 20);
      bus1.btn_raw = 3'b000;

      // dut2: re-press while the stretch counter holds 3.
      a = c + 40;
      goto(a - 1);
      bus2.btn_raw[0] = 1'b1;
      goto(a + 1);
      bus2.btn_raw[0] = 1'b0;
      push_ev(K_PRESS, 4, a + 4);
      push_ev(K_STRR, 4, a + 4);
      push_ev(K_REL, 4, a + 6);
      push_ev(K_PRESS, 4, a + 34);
      push_ev(K_STRF, 4, a + 66);
      push_ev(K_REL, 4, a + 74);
      goto(a + 29);
      bus2.btn_raw[0] = 1'b1;
      goto(a + 33);
      check_eq("t4_str_before_repress", bus2.btn_press_str, 3'b001);
      goto(a + 65);
      check_eq("t4_str_end", bus2.btn_press_str, 3'b001);
      goto(a + 69);
      bus2.btn_raw[0] = 1'b0;

      // dut2: three simultaneous presses, nextString watched by the slowerCLK sampler.
      d = a + 90;
      for (int n = 0; n < 3; n++) begin
         r = d + n * 100;
         goto(r - 1);
         bus2.btn_raw = 3'b111;
         for (int i = 0; i < 3; i++) begin
            push_ev(K_PRESS, i + 4, r + 4);
            push_ev(K_STRR, i + 4, r + 4);
            push_ev(K_STRF, i + 4, r + 36);
            push_ev(K_REL, i + 4, r + 9);
         end
         goto(r + 4);
         bus2.btn_raw = 3'b000;
      end

      // Reset in mid-stretch with buttons held through reset.
      e = d + 260;
      goto(e);
      bus1.btn_raw[0] = 1'b1;
      push_ev(K_PRESS, 0, e + 7);
      push_ev(K_STRR, 0, e + 7);
      goto(e + 10);
      bus1.btn_raw[2] = 1'b1;
      #2 reset = 1'b1;
      #1;
      check_zero1("t5_async");
      push_ev(K_STRF, 0, e + 11);
      goto(e + 14);
      check_zero1("t5_in_reset");
      reset = 1'b0;
      t1 = cyc;
      for (int i = 0; i < 3; i += 2) begin
         push_ev(K_PRESS, i, t1 + 7);
         push_ev(K_STRR, i, t1 + 7);
         push_ev(K_STRF, i, t1 + 15);
         push_ev(K_REL, i, t1 + 26);
      end
      goto(t1 + 1);
      check_zero1("t5_first_edge");
      goto(t1 + 5);
      check_eq("t5_level_pre", bus1.btn_level, 3'b000);
      goto(t1 + 6);
      check_eq("t5_level_rise", bus1.btn_level, 3'b101);
      goto(t1 + 19);
      bus1.btn_raw = 3'b000;
      goto(t1 + 40);

      check_eq("slow_samples", slow_cnt, 3);
      foreach (exp_q[j]) check_eq("missing_event", 32'd0, exp_q[j]);
      check_eq("pending_events", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the raw GPIO push-button inputs (clearAll, resetFSM, nextString) before they reach lcd_control and testFSM.
- Per channel: 2-FF synchronizer into USER_CLK, counter-based debouncer, debounced level, single-cycle press and release pulses.
- Also produces a stretched press pulse, so the USER_CLK/32 slowerCLK domain samples every press exactly once.
- Instanced in the LCD top level between the GPIO_SW_* pins and the consumers; GPIO_SW_C stays the raw system reset.

Parameters:
NUM_BTN, 3, number of independent button channels
DEBOUNCE_CYCLES, 250000, consecutive USER_CLK cycles a synchronized input must differ from the debounced level before the level flips (min 2)
PULSE_CYCLES, 32, width in USER_CLK cycles of btn_press_str; must be >= one slowerCLK period (32)

Ports:
USER_CLK  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_raw  input  NUM_BTN  raw asynchronous button inputs, bit i = channel i
btn_level  output  NUM_BTN  debounced button level
btn_press  output  NUM_BTN  1-cycle pulse on debounced rising edge
btn_release  output  NUM_BTN  1-cycle pulse on debounced falling edge
btn_press_str  output  NUM_BTN  press pulse stretched to PULSE_CYCLES cycles

Behaviour:
- Reset clears all state asynchronously; every channel is independent with identical logic:
  - sync flops, level, debounce counter and stretch counter go to 0
  - all outputs go to 0 while reset is high and on the first edge after release
- Synchronizer: s1 <= btn_raw[i]; s2 <= s1. Only s2 feeds the debouncer; btn_raw is never used combinationally.
- Debounce counter (width clog2(DEBOUNCE_CYCLES)+1):
  - s2 == level: counter <= 0
  - s2 != level and counter == DEBOUNCE_CYCLES-1: level <= s2, counter <= 0
  - otherwise: counter <= counter+1
  - Any glitch back to the level value restarts the count from 0. Shorter bounces never change level.
- Latency: raw held stable from before edge k -> level changes on edge k+1+DEBOUNCE_CYCLES (2-cycle sync plus DEBOUNCE_CYCLES).
- btn_press / btn_release:
  - Registered; high for exactly the one cycle after level goes 0->1 / 1->0.
  - Never both high on the same channel.
- Stretch counter (width clog2(PULSE_CYCLES)+1):
  - Loaded with PULSE_CYCLES on the same edge btn_press is asserted.
  - Decrements to 0; btn_press_str = (stretch counter != 0), registered.
  - New press while counter nonzero: counter reloads to PULSE_CYCLES, output stays high continuously with no gap.
  - Release has no effect on the stretch.
- Button already held when reset deasserts: treated as a press. level rises DEBOUNCE_CYCLES+2 cycles after reset release, and press/stretch fire normally.
- Reset mid-count or mid-stretch: everything aborts to 0; no partial pulse after reset release.
- Counters never wrap. The debounce counter saturates by construction (cleared at DEBOUNCE_CYCLES-1); the stretch counter stops at 0.
- Bench builds may set DEBOUNCE_CYCLES small (e.g. 4); behaviour must be identical apart from timing.

Test Plan:
1. DEBOUNCE_CYCLES=4, PULSE_CYCLES=8. Assert reset, then raise btn_raw[0] cleanly at edge 10 -> btn_level[0] rises on edge 15. btn_press[0] is high only for cycle 16. btn_press_str[0] is high cycles 16-23. Channels 1-2 stay 0 throughout.
2. Bounce: btn_raw[1] toggles 1,0,1,0 with 3-cycle dwell, then holds 1 -> no change on level/press until 4 stable synchronized cycles; exactly one btn_press[1] pulse total.
3. Release: from level=1, drop btn_raw[0] -> btn_release[0] single pulse 6 cycles later. btn_press_str[0] is unaffected if still active. Glitch of 3 cycles low produces no release.
4. Re-press during stretch (debounce set to 2): second press pulse at stretch count 3 -> btn_press_str stays high continuously for PULSE_CYCLES cycles after the second press.
5. Button held through reset -> after reset release, level rises at DEBOUNCE_CYCLES+2 and one press pulse fires. Reset asserted mid-stretch -> btn_press_str drops asynchronously, stays 0 after release.
6. All three channels pressed on the same cycle -> all three press pulses coincide. Verify with divided 32-cycle slowerCLK sampling that testFSM sees nextString exactly once per press.
